// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular exponentiation engine and its multiplier.
package rsa_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    MUL    = 3'd2,
    SQR    = 3'd3,
    DONE   = 3'd4
  } modexp_state_t;

  // Smallest r such that 2**r >= value; used to size counters.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rsa_modmul_seq.sv
// Interleaved shift-add modular multiplier: p = a*b mod n in exactly WIDTH cycles, MSB of a first.
// The first step runs in the cycle start is accepted; done is high during the last step with p valid.
module rsa_modmul_seq import rsa_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_n,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_p
);

  localparam int CW = clog2(WIDTH);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_n;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;

  logic             w_load;
  logic             w_active;
  logic             w_last;
  logic [WIDTH-1:0] w_acc;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_n;
  logic [CW-1:0]    w_idx;
  logic [WIDTH:0]   w_dbl;
  logic [WIDTH-1:0] w_dbl_red;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_sum_red;

  assign w_load   = i_start && !r_busy;
  assign w_active = w_load || r_busy;

  // On the load cycle the step works straight from the ports so no cycle is lost.
  always_comb begin
    w_acc = w_load ? '0    : r_acc;
    w_a   = w_load ? i_a   : r_a;
    w_b   = w_load ? i_b   : r_b;
    w_n   = w_load ? i_n   : r_n;
    w_idx = w_load ? '0    : r_cnt;

    w_dbl     = {w_acc, 1'b0};
    w_dbl_red = (w_dbl >= {1'b0, w_n}) ? WIDTH'(w_dbl - {1'b0, w_n}) : w_dbl[WIDTH-1:0];
    w_sum     = w_a[WIDTH-1] ? ({1'b0, w_dbl_red} + {1'b0, w_b}) : {1'b0, w_dbl_red};
    w_sum_red = (w_sum >= {1'b0, w_n}) ? WIDTH'(w_sum - {1'b0, w_n}) : w_sum[WIDTH-1:0];
  end

  assign w_last = (w_idx == CW'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_n    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (w_active) begin
      r_acc  <= w_sum_red;
      r_a    <= {w_a[WIDTH-2:0], 1'b0};
      r_b    <= w_b;
      r_n    <= w_n;
      r_cnt  <= w_idx + CW'(1);
      r_busy <= !w_last;
    end
  end

  assign o_busy = r_busy;
  assign o_done = w_active && w_last;
  assign o_p    = w_sum_red;

endmodule

// File: rtl/rsa_modexp_seq.sv
// Right-to-left square-and-multiply modular exponentiation: o_result = base^exp mod mod.
// Define MODEXP_EARLY_TERM_EN to skip dummy multiplies and stop at the top set exponent bit.
module rsa_modexp_seq import rsa_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_base,
  input  logic [WIDTH-1:0] i_exp,
  input  logic [WIDTH-1:0] i_mod,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int CNTW = clog2(WIDTH + 1);
`ifdef MODEXP_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  modexp_state_t    r_state;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_e;
  logic [WIDTH-1:0] r_n;
  logic [CNTW-1:0]  r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic             w_accept;
  logic             w_mm_start;
  logic             w_mm_busy;
  logic             w_mm_done;
  logic [WIDTH-1:0] w_mm_a;
  logic [WIDTH-1:0] w_mm_b;
  logic [WIDTH-1:0] w_mm_p;
  logic             w_e_hi_zero;

  assign w_accept    = i_start && !r_busy;
  assign w_e_hi_zero = (r_e[WIDTH-1:1] == '0);

  // r_b holds the raw base until REDUCE replaces it with base mod n.
  always_comb begin
    w_mm_a = r_b;
    w_mm_b = r_b;
    case (r_state)
      REDUCE:  w_mm_b = WIDTH'(1);
      MUL:     w_mm_a = r_r;
      default: ;
    endcase
    w_mm_start = ((r_state == REDUCE) || (r_state == MUL) || (r_state == SQR)) && !w_mm_busy;
  end

  rsa_modmul_seq #(.WIDTH(WIDTH)) u_modmul (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (w_mm_start),
    .i_a     (w_mm_a),
    .i_b     (w_mm_b),
    .i_n     (r_n),
    .o_busy  (w_mm_busy),
    .o_done  (w_mm_done),
    .o_p     (w_mm_p)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_r      <= '0;
      r_b      <= '0;
      r_e      <= '0;
      r_n      <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          r_state <= IDLE;
          if (w_accept) begin
            r_b   <= i_base;
            r_e   <= i_exp;
            r_n   <= i_mod;
            r_r   <= (i_mod == WIDTH'(1)) ? '0 : WIDTH'(1);
            r_cnt <= '0;
            if (i_mod == '0) begin
              r_state  <= DONE;
              r_done   <= 1'b1;
              r_result <= '0;
            end else begin
              r_state <= REDUCE;
              r_busy  <= 1'b1;
            end
          end
        end
        REDUCE: begin
          if (w_mm_done) begin
            r_b <= w_mm_p;
            if (EARLY_TERM && (r_e == '0)) begin
              r_state  <= DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_result <= r_r;
            end else if (EARLY_TERM && !r_e[0]) begin
              r_state <= SQR;
            end else begin
              r_state <= MUL;
            end
          end
        end
        MUL: begin
          if (w_mm_done) begin
            // In the constant-time build a clear bit still multiplies; the product is dropped.
            if (r_e[0]) r_r <= w_mm_p;
            if (EARLY_TERM && w_e_hi_zero) begin
              r_state  <= DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_result <= w_mm_p;
            end else begin
              r_state <= SQR;
            end
          end
        end
        SQR: begin
          if (w_mm_done) begin
            r_b   <= w_mm_p;
            r_e   <= r_e >> 1;
            r_cnt <= r_cnt + CNTW'(1);
            if (!EARLY_TERM && (r_cnt == CNTW'(WIDTH - 1))) begin
              r_state  <= DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_result <= r_r;
            end else if (EARLY_TERM && !r_e[1]) begin
              r_state <= SQR;
            end else begin
              r_state <= MUL;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_rsa_modexp_seq.sv
// Directed and model-checked bench for rsa_modexp_seq at WIDTH=8 (either build of MODEXP_EARLY_TERM_EN).
module tb_rsa_modexp_seq;

  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         i_start;
  logic [W-1:0] i_base;
  logic [W-1:0] i_exp;
  logic [W-1:0] i_mod;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_result;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] base;
    logic [W-1:0] ex;
    logic [W-1:0] md;
    logic [W-1:0] res;
  } vec_t;

  vec_t vecs[12];

  rsa_modexp_seq #(.WIDTH(W)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (i_start),
    .i_base   (i_base),
    .i_exp    (i_exp),
    .i_mod    (i_mod),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result)
  );

  always #5 i_clk = ~i_clk;

  function automatic int exp_latency(input logic [W-1:0] e, input logic [W-1:0] md);
    int pop;
    int msb;
    pop = 0;
    msb = 0;
    for (int i = 0; i < W; i++) begin
      if (e[i]) begin
        pop++;
        msb = i;
      end
    end
    if (md == '0) return 1;
`ifdef MODEXP_EARLY_TERM_EN
    if (e == '0) return 1 + W;
    return 1 + W * (1 + pop + msb);
`else
    return 1 + W * (1 + 2 * W) + 0 * (pop + msb);
`endif
  endfunction

  // Repeated multiplication, deliberately unlike square-and-multiply.
  function automatic logic [W-1:0] model(input logic [W-1:0] b, input logic [W-1:0] e,
                                         input logic [W-1:0] m);
    int r;
    int bb;
    int mm;
    int ee;
    if (m == '0) return '0;
    mm = int'(m);
    bb = int'(b);
    ee = int'(e);
    r  = 1 % mm;
    for (int i = 0; i < ee; i++) r = (r * bb) % mm;
    return W'(r);
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle (or after the cycle budget).
  task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                        output logic [W-1:0] res, output int lat, output bit busy_ok);
    i_base  = b;
    i_exp   = e;
    i_mod   = m;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (!o_done && lat < 2000) begin
      if (!o_busy) busy_ok = 1'b0;
      @(negedge i_clk);
      lat++;
    end
    if (o_busy) busy_ok = 1'b0;
    res = o_result;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] b, input logic [W-1:0] e,
                          input logic [W-1:0] m, input logic [W-1:0] expres);
    logic [W-1:0] res;
    int           lat;
    bit           busy_ok;
    run_op(b, e, m, res, lat, busy_ok);
    chk({name, "_result"}, int'(res), int'(expres));
    chk({name, "_latency"}, lat, exp_latency(e, m));
    chk({name, "_busy"}, int'(busy_ok), 1);
    $display("op %s base=%0d exp=%0d mod=%0d result=%0d latency=%0d", name, b, e, m, res, lat);
  endtask

  initial begin
    int           ndone;
    int           d1;
    int           d2;
    int           lat;
    logic [W-1:0] rb;
    logic [W-1:0] re;
    logic [W-1:0] rm;

    vecs[0]  = '{8'd5,   8'd7,   8'd33,  8'd14};
    vecs[1]  = '{8'd14,  8'd3,   8'd33,  8'd5};
    vecs[2]  = '{8'd200, 8'd1,   8'd33,  8'd2};
    vecs[3]  = '{8'd4,   8'd13,  8'd77,  8'd53};
    vecs[4]  = '{8'd9,   8'd0,   8'd33,  8'd1};
    vecs[5]  = '{8'd123, 8'd45,  8'd1,   8'd0};
    vecs[6]  = '{8'd77,  8'd5,   8'd0,   8'd0};
    vecs[7]  = '{8'd3,   8'd4,   8'd7,   8'd4};
    vecs[8]  = '{8'd254, 8'd2,   8'd255, 8'd1};
    vecs[9]  = '{8'd255, 8'd2,   8'd254, 8'd1};
    vecs[10] = '{8'd0,   8'd0,   8'd33,  8'd1};
    vecs[11] = '{8'd10,  8'd2,   8'd200, 8'd100};

    i_reset = 1'b1;
    i_start = 1'b0;
    i_base  = '0;
    i_exp   = '0;
    i_mod   = '0;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_done", int'(o_done), 0);
    chk("reset_result", int'(o_result), 0);
    @(negedge i_clk);

    for (int i = 0; i < 12; i++) begin
      check_op($sformatf("vec%0d", i), vecs[i].base, vecs[i].ex, vecs[i].md, vecs[i].res);
      @(negedge i_clk);
    end

    // Reset in the middle of an operation: aborted, cleared, and no done afterwards.
    check_op("t5_pre", 8'd5, 8'd7, 8'd33, 8'd14);
    i_base  = 8'd5;
    i_exp   = 8'd7;
    i_mod   = 8'd33;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (39) @(negedge i_clk);
    chk("t5_busy_c40", int'(o_busy), 1);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    chk("t5_abort_busy", int'(o_busy), 0);
    chk("t5_abort_result", int'(o_result), 0);
    ndone = 0;
    for (int c = 0; c < 200; c++) begin
      if (o_done) ndone++;
      @(negedge i_clk);
    end
    chk("t5_no_done", ndone, 0);
    $display("op abort_at_cycle40 dones_after=%0d", ndone);
    check_op("t5_recover", 8'd4, 8'd13, 8'd77, 8'd53);
    @(negedge i_clk);

    // Start held high: ignored while busy, re-accepted in the done cycle (back-to-back).
    lat     = exp_latency(8'd7, 8'd33);
    i_base  = 8'd5;
    i_exp   = 8'd7;
    i_mod   = 8'd33;
    i_start = 1'b1;
    ndone   = 0;
    d1      = 0;
    d2      = 0;
    for (int c = 1; c <= 2 * lat + 20; c++) begin
      @(negedge i_clk);
      if (d1 > 0 && c == d1 + 1) i_start = 1'b0;
      if (o_done) begin
        ndone++;
        if (ndone == 1) d1 = c;
        if (ndone == 2) begin
          d2 = c;
          chk("hold_second_result", int'(o_result), 14);
        end
      end
    end
    chk("hold_first_done_cycle", d1, lat);
    chk("hold_second_done_cycle", d2, 2 * lat);
    chk("hold_done_count", ndone, 2);
    $display("op held_start first_done=%0d second_done=%0d dones=%0d", d1, d2, ndone);
    i_start = 1'b0;
    @(negedge i_clk);

    // Random operands against the reference model.
    for (int k = 0; k < 30; k++) begin
      rb = W'($urandom_range(0, 255));
      re = W'($urandom_range(0, 255));
      rm = W'($urandom_range(0, 255));
      if (k == 0) rm = 8'd2;
      check_op($sformatf("rand%0d", k), rb, re, rm, model(rb, re, rm));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
